draw_ball: RTL and testbench

- Video pipeline stage directly downstream of the racket-drawing stage.
- Consumes its timing stream and RGB, overlays the ball, and re-registers everything for the next stage.
- Owns the ball: a per-frame motion FSM handling wall bounces, racket hits and goal detection.
- Emits goal pulses to the score logic.

---
 rtl/draw_ball.sv | 151 +++++++++++++++
 tb/tb_draw_ball.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/draw_ball.sv
// draw_ball: overlays the ball on the pixel stream and runs its per-frame motion FSM.
// Define BALL_SPEEDUP_EN to make the ball speed up by one pixel per racket hit, up to twice SPEED.
module draw_ball #(
  parameter int BALL_SIZE   = 8,
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int SPEED       = 4,
  parameter int HOLD_FRAMES = 60,
  parameter int L_FACE      = 60,
  parameter int R_FACE      = 963,
  parameter int RACKET_LEN  = 80
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [9:0]  y_pos,
  input  logic [11:0] y_pos_sec,
  input  logic [11:0] ball_color,
  input  logic        serve,
  input  logic        serve_dir,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        goal_left,
  output logic        goal_right,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y
);
  localparam logic [11:0] BS = 12'(BALL_SIZE);
  localparam logic [11:0] W  = 12'(SCREEN_W);
  localparam logic [11:0] H  = 12'(SCREEN_H);
  localparam logic [11:0] LF = 12'(L_FACE);
  localparam logic [11:0] RF = 12'(R_FACE);
  localparam logic [11:0] RL = 12'(RACKET_LEN);
  localparam logic [11:0] SP = 12'(SPEED);
  localparam logic [10:0] CX = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0] CY = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam int CW = $clog2(HOLD_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, MOVE, SCORED} state_t;
  state_t state_q;
  logic dir_x_q, dir_y_q, vblnk_q;
  logic [CW-1:0] cnt_q;
  logic [11:0] sp;
`ifdef BALL_SPEEDUP_EN
  localparam logic [11:0] SP_MAX = 12'(2 * SPEED);
  logic [11:0] sp_q;
  assign sp = sp_q;
`else
  assign sp = SP;
`endif
  logic [11:0] bx, by, yl, hx, vy;
  logic tick, ov_l, ov_r, hit_l, hit_r, goal_l, goal_r, top, bot, in_ball, ndx, ndy;
  logic [10:0] mv_x, mv_y;
  // all geometry is compared at 12 bits so sums near the screen edge never wrap
  always_comb begin
    bx      = {1'b0, ball_x};
    by      = {1'b0, ball_y};
    yl      = {2'b0, y_pos};
    hx      = {1'b0, hcount_in};
    vy      = {1'b0, vcount_in};
    tick    = vblnk_in & ~vblnk_q;
    ov_l    = (by + BS > yl) && (by < yl + RL);
    ov_r    = (by + BS > y_pos_sec) && (by < y_pos_sec + RL);
    hit_l   = !dir_x_q && bx >= LF && bx - sp < LF && ov_l;
    hit_r   = dir_x_q && bx + BS <= RF && bx + BS + sp > RF && ov_r;
    goal_r  = !dir_x_q && !hit_l && bx < sp;
    goal_l  = dir_x_q && !hit_r && bx + BS + sp > W;
    mv_x    = 11'(hit_l ? LF : hit_r ? RF - BS : (goal_l || goal_r) ? bx : dir_x_q ? bx + sp : bx - sp);
    ndx     = hit_l ? 1'b1 : hit_r ? 1'b0 : dir_x_q;
    top     = !dir_y_q && by < sp;
    bot     = dir_y_q && by + BS + sp > H;
    mv_y    = 11'(top ? 12'd0 : bot ? H - BS : dir_y_q ? by + sp : by - sp);
    ndy     = top ? 1'b1 : bot ? 1'b0 : dir_y_q;
    in_ball = hx >= bx && hx < bx + BS && vy >= by && vy < by + BS && state_q != SCORED;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      vcount_out <= '0;
      hcount_out <= '0;
      vsync_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
      goal_left  <= 1'b0;
      goal_right <= 1'b0;
      ball_x     <= CX;
      ball_y     <= CY;
      state_q    <= IDLE;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      cnt_q      <= '0;
      vblnk_q    <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      sp_q       <= SP;
`endif
    end else begin
      vcount_out <= vcount_in;
      hcount_out <= hcount_in;
      vsync_out  <= vsync_in;
      hsync_out  <= hsync_in;
      vblnk_out  <= vblnk_in;
      hblnk_out  <= hblnk_in;
      rgb_out    <= in_ball ? ball_color : rgb_in;
      vblnk_q    <= vblnk_in;
      goal_left  <= 1'b0;
      goal_right <= 1'b0;
      case (state_q)
        IDLE: if (serve) begin
          state_q <= MOVE;
          dir_x_q <= serve_dir;
          dir_y_q <= 1'b1;
`ifdef BALL_SPEEDUP_EN
          sp_q    <= SP;
`endif
        end
        MOVE: if (tick) begin
          ball_x     <= mv_x;
          ball_y     <= mv_y;
          dir_x_q    <= ndx;
          dir_y_q    <= ndy;
          goal_left  <= goal_l;
          goal_right <= goal_r;
          if (goal_l || goal_r) state_q <= SCORED;
`ifdef BALL_SPEEDUP_EN
          if ((hit_l || hit_r) && sp_q != SP_MAX) sp_q <= sp_q + 12'd1;
`endif
        end
        SCORED: if (tick) begin
          if (cnt_q == CW'(HOLD_FRAMES - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ball_x  <= CX;
            ball_y  <= CY;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_ball.sv
// tb_draw_ball: scoreboard bench for draw_ball; expectations queued by stimulus, checked by a monitor.
module tb_draw_ball;
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  logic rst, vsync_in, hsync_in, vblnk_in, hblnk_in, serve, serve_dir;
  logic [10:0] vcount_in, hcount_in;
  logic [11:0] rgb_in, y_pos_sec, ball_color;
  logic [9:0] y_pos;
  logic [10:0] vcount_out, hcount_out, ball_x, ball_y;
  logic vsync_out, hsync_out, vblnk_out, hblnk_out, goal_left, goal_right;
  logic [11:0] rgb_out;
  draw_ball dut (
    .pclk(pclk), .rst(rst), .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .y_pos(y_pos), .y_pos_sec(y_pos_sec), .ball_color(ball_color),
    .serve(serve), .serve_dir(serve_dir), .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .goal_left(goal_left), .goal_right(goal_right),
    .ball_x(ball_x), .ball_y(ball_y)
  );
  typedef struct {
    int          sig;
    logic [11:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int failed = 0;
  function automatic logic [11:0] act(input int s);
    case (s)
      0: return {1'b0, ball_x};
      1: return {1'b0, ball_y};
      2: return rgb_out;
      3: return {11'd0, goal_left};
      4: return {11'd0, goal_right};
      5: return {1'b0, hcount_out};
      6: return {1'b0, vcount_out};
      7: return {8'd0, vsync_out, hsync_out, vblnk_out, hblnk_out};
      default: return 12'hFFF;
    endcase
  endfunction
  always @(negedge pclk) begin : monitor
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      tests++;
      if (act(e.sig) !== e.exp) begin
        failed++;
        $display("FAIL %s at %0t: got %0d expected %0d", e.name, $time, act(e.sig), e.exp);
      end
    end
  end
  task automatic check(input int s, input logic [11:0] v, input string n);
    tests++;
    if (act(s) !== v) begin
      failed++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act(s), v);
    end
  endtask
  task automatic push(input int s, input logic [11:0] v, input string n);
    sb.push_back('{sig: s, exp: v, name: n});
  endtask
  task automatic step();
    @(posedge pclk);
    #1;
  endtask
  task automatic frame(input logic gl, input logic gr);
    vblnk_in = 1'b1;
    step();
    push(3, {11'd0, gl}, "goal_left_tick");
    push(4, {11'd0, gr}, "goal_right_tick");
    vblnk_in = 1'b0;
    step();
    push(3, 12'd0, "goal_left_after");
    push(4, 12'd0, "goal_right_after");
  endtask
  task automatic serve_pulse(input logic d);
    serve = 1'b1;
    serve_dir = d;
    step();
    serve = 1'b0;
  endtask
  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] e);
    hcount_in = h;
    vcount_in = v;
    step();
    push(2, e, "rgb_out");
    push(5, {1'b0, h}, "hcount_out");
    push(6, {1'b0, v}, "vcount_out");
  endtask
  task automatic pos(input logic [10:0] x, input logic [10:0] y);
    push(0, {1'b0, x}, "ball_x");
    push(1, {1'b0, y}, "ball_y");
  endtask
  initial begin
    rst = 1'b1; vsync_in = 1'b0; hsync_in = 1'b1; vblnk_in = 1'b0; hblnk_in = 1'b0;
    serve = 1'b0; serve_dir = 1'b0; vcount_in = 11'd50; hcount_in = 11'd100;
    rgb_in = 12'h0A5; ball_color = 12'hF00; y_pos = 10'd0; y_pos_sec = 12'd2000;
    step();
    step();
    check(0, 12'd508, "rst_ball_x_now");
    pos(11'd508, 11'd380);
    push(2, 12'h000, "rst_rgb_out");
    push(5, 12'd0, "rst_hcount_out");
    push(7, 12'd0, "rst_timing");
    push(3, 12'd0, "rst_goal_left");
    push(4, 12'd0, "rst_goal_right");
    rst = 1'b0;
    pix(11'd508, 11'd380, 12'hF00);
    pix(11'd515, 11'd387, 12'hF00);
    pix(11'd516, 11'd380, 12'h0A5);
    pix(11'd508, 11'd388, 12'h0A5);
    pix(11'd507, 11'd383, 12'h0A5);
    vsync_in = 1'b1; hblnk_in = 1'b1;
    step();
    push(7, 12'b1101, "timing_out");
    vsync_in = 1'b0; hblnk_in = 1'b0;
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    pos(11'd508, 11'd380);
    serve_pulse(1'b1);
    for (int n = 1; n <= 128; n++) begin
      frame(n == 128, 1'b0);
      if (n == 1) pos(11'd512, 11'd384);
      if (n == 2) pos(11'd516, 11'd388);
      if (n == 95 || n == 96) push(1, 12'd760, "ball_y_bottom");
      if (n == 97) push(1, 12'd756, "ball_y_after_bounce");
      if (n == 127) push(0, 12'd1016, "ball_x_edge");
    end
    pix(11'd1020, 11'd638, 12'h0A5);
    serve_pulse(1'b0);
    for (int k = 1; k <= 60; k++) begin
      frame(1'b0, 1'b0);
      if (k == 59) push(0, 12'd1016, "ball_x_held");
      if (k == 60) pos(11'd508, 11'd380);
    end
    check(0, 12'd508, "expired_wait_ball_x");
    frame(1'b0, 1'b0);
    push(0, 12'd508, "idle_after_ignored_serve");
    pix(11'd510, 11'd382, 12'hF00);
    serve_pulse(1'b0);
    for (int n = 1; n <= 128; n++) begin
      frame(1'b0, n == 128);
      if (n == 1) pos(11'd504, 11'd384);
      if (n == 112) push(0, 12'd60, "ball_x_at_face");
      if (n == 113) push(0, 12'd56, "ball_x_missed");
      if (n == 127) push(0, 12'd0, "ball_x_left_edge");
    end
    for (int k = 1; k <= 60; k++) begin
      frame(1'b0, 1'b0);
      if (k == 60) pos(11'd508, 11'd380);
    end
    y_pos = 10'd650;
    serve_pulse(1'b0);
    for (int n = 1; n <= 290; n++) begin
      frame(1'b0, 1'b0);
      if (n == 112) push(0, 12'd60, "ball_x_pre_hit");
      if (n == 113) pos(11'd60, 11'd692);
      if (n == 114) pos(11'd64, 11'd688);
      if (n == 285) push(1, 12'd4, "ball_y_near_top");
      if (n == 286 || n == 287) push(1, 12'd0, "ball_y_top");
      if (n == 288) pos(11'd760, 11'd4);
    end
    hcount_in = 11'd300;
    rst = 1'b1;
    step();
    pos(11'd508, 11'd380);
    push(2, 12'h000, "midrst_rgb_out");
    push(5, 12'd0, "midrst_hcount_out");
    push(3, 12'd0, "midrst_goal_left");
    push(4, 12'd0, "midrst_goal_right");
    rst = 1'b0;
    frame(1'b0, 1'b0);
    pos(11'd508, 11'd380);
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
